// File: rtl/mips_defs.sv
// Shared definitions for the pipeline hazard unit: divide FSM states,
// forwarding-select codes and the register-match helper.
package mips_defs;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } divState_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // $0 is hardwired to zero, so a write to it must never be forwarded.
  function automatic logic regHit(input logic regwrite, input logic [4:0] dst,
                                  input logic [4:0] src);
    return regwrite & (dst != 5'd0) & (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle; the pipeline is the master,
// the hazard unit the slave.
interface hazard_unit_if;
  logic [4:0] rsD, rtD;
  logic [4:0] rsE, rtE, writeregE;
  logic [4:0] writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM, branchD;
  logic       divE, divreadyE;

  logic       divstartE;
  logic       stallF, stallD, stallE;
  logic       flushE;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD,
           divE, divreadyE,
    input  divstartE, stallF, stallD, stallE, flushE,
           forwardaD, forwardbD, forwardaE, forwardbE
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD,
           divE, divreadyE,
    output divstartE, stallF, stallD, stallE, flushE,
           forwardaD, forwardbD, forwardaE, forwardbE
  );
endinterface

// File: rtl/fwd_sel.sv
// ALU operand bypass select for one execute-stage source register;
// a mem-stage producer is younger than writeback, so it wins.
module fwd_sel
  import mips_defs::*;
(
  input  logic [4:0] srcE,
  input  logic       regwriteM,
  input  logic [4:0] writeregM,
  input  logic       regwriteW,
  input  logic [4:0] writeregW,
  output logic [1:0] fwdSel
);

  always_comb begin
    fwdSel = FWD_REG;
    if (regHit(regwriteM, writeregM, srcE))
      fwdSel = FWD_MEM;
    else if (regHit(regwriteW, writeregW, srcE))
      fwdSel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stalls and the
// multi-cycle divide handshake.
//   state    | meaning
//   DIV_IDLE | no divide outstanding; divE launches one
//   DIV_BUSY | divider running, pipeline held until divreadyE
module hazard_unit
  import mips_defs::*;
(
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hz
);

  divState_t state, stateNext;
  logic      lwstall, branchstall, divstall, divStart;

  fwd_sel uFwdA (
    .srcE(hz.rsE), .regwriteM(hz.regwriteM), .writeregM(hz.writeregM),
    .regwriteW(hz.regwriteW), .writeregW(hz.writeregW), .fwdSel(hz.forwardaE)
  );

  fwd_sel uFwdB (
    .srcE(hz.rtE), .regwriteM(hz.regwriteM), .writeregM(hz.writeregM),
    .regwriteW(hz.regwriteW), .writeregW(hz.writeregW), .fwdSel(hz.forwardbE)
  );

  assign hz.forwardaD = regHit(hz.regwriteM, hz.writeregM, hz.rsD);
  assign hz.forwardbD = regHit(hz.regwriteM, hz.writeregM, hz.rtD);

  assign lwstall = hz.memtoregE & ((hz.rtE == hz.rsD) | (hz.rtE == hz.rtD));

  assign branchstall = hz.branchD &
    ((hz.regwriteE & ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD))) |
     (hz.memtoregM & ((hz.writeregM == hz.rsD) | (hz.writeregM == hz.rtD))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    divStart  = 1'b0;
    divstall  = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (hz.divE) begin
          divStart  = 1'b1;
          divstall  = 1'b1;
          stateNext = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (hz.divreadyE) stateNext = DIV_IDLE;
        else              divstall  = 1'b1;
      end
    endcase
    // Outputs are quiet for the whole reset window, not just after the edge.
    if (!rst) begin
      divStart = 1'b0;
      divstall = 1'b0;
    end
  end

  assign hz.divstartE = divStart;
  assign hz.stallF    = lwstall | branchstall | divstall;
  assign hz.stallD    = lwstall | branchstall | divstall;
  assign hz.stallE    = divstall;
  assign hz.flushE    = (lwstall | branchstall) & ~divstall;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide ports: rsD, rtD  input  5 each  decode-stage source register numbers.
REQ-004 SHALL provide ports: rsE, rtE, writeregE  input  5 each  execute-stage sources and destination.
REQ-005 SHALL provide ports: writeregM, writeregW  input  5 each  mem and writeback destinations.
REQ-006 SHALL provide ports: regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD  input  1 each  stage controls from the pipeline controller.
REQ-007 SHALL provide port: divE  input  1  divide instruction present in execute.
REQ-008 SHALL provide port: divreadyE  input  1  divider result valid this cycle.
REQ-009 SHALL provide port: divstartE  output  1  one-cycle start pulse to the divider.
REQ-010 SHALL provide ports: stallF, stallD, stallE  output  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-011 SHALL provide port: flushE  output  1  clear ID/EX controls; this is the pipeline controller's flushE.
REQ-012 SHALL provide ports: forwardaD, forwardbD  output  1 each  branch-compare bypass from mem stage.
REQ-013 SHALL provide ports: forwardaE, forwardbE  output  2 each  ALU operand select: 00 regfile, 01 writeback, 10 mem.

Function
REQ-014 SHALL drive forwardaE = 10 when regwriteM, writeregM!=0 and writeregM==rsE.
REQ-015 SHALL otherwise drive forwardaE = 01 when regwriteW, writeregW!=0 and writeregW==rsE; otherwise 00.
REQ-016 SHALL apply REQ-014/015 to forwardbE using rtE; mem-stage match has priority over writeback match.
REQ-017 SHALL drive forwardaD/forwardbD = regwriteM & writeregM!=0 & (writeregM==rsD / rtD).
REQ-018 SHALL compute lwstall = memtoregE & (rtE==rsD | rtE==rtD).
REQ-019 SHALL compute branchstall = branchD & ((regwriteE & writeregE in {rsD,rtD}) | (memtoregM & writeregM in {rsD,rtD})).
REQ-020 SHALL use a divide FSM with states IDLE and BUSY.
REQ-021 In IDLE with divE=1, SHALL assert divstartE for exactly that cycle, assert divstall, and enter BUSY next edge.
REQ-022 In BUSY, SHALL hold divstartE=0 and assert divstall while divreadyE=0.
REQ-023 In BUSY with divreadyE=1, SHALL deassert divstall that same cycle and return to IDLE.
REQ-024 SHALL ignore divreadyE while in IDLE.
REQ-025 SHALL drive stallF = stallD = lwstall | branchstall | divstall, and stallE = divstall.
REQ-026 SHALL drive flushE = (lwstall | branchstall) & ~divstall; a divide stall never flushes execute.
REQ-027 A divide in E in the cycle after a return to IDLE is a new instruction; back-to-back divides SHALL restart per REQ-021.
REQ-028 All outputs except FSM-derived terms SHALL be purely combinational, with zero-cycle latency.

Reset
REQ-029 rst low SHALL force IDLE immediately, independent of clk; divstartE=0 and divstall=0 while rst is low.
REQ-030 A reset asserted while in BUSY SHALL abandon the divide; no divstartE is issued until divE is seen after release.

Structure
REQ-031 The shared package (mips_defs) SHALL hold FSM state encodings and the FWD_REG/FWD_WB/FWD_MEM constants.
REQ-032 Forward selection SHALL be one sub-module, fwd_sel, instantiated twice (operand a and operand b).

Verification
REQ-033 Check: add $1 writes in M, rsE=1 -> forwardaE=10; with the same write in W only -> 01; with writeregM=0 -> 00.
REQ-034 Check: lw to $2 in E (memtoregE=1, rtE=2) with rsD=2 -> stallF=stallD=flushE=1 for one cycle, then 0.
REQ-035 Check: beq with rsD=3 and regwriteE=1, writeregE=3 -> branchstall=1; next cycle with writeregM=3 and memtoregM=0 -> forwardaD=1 and no stall.
REQ-036 Check: divE=1 in IDLE -> divstartE pulse of 1 cycle; stallF/D/E=1 for 5 cycles; divreadyE on cycle 6 -> stalls=0 that cycle; flushE=0 throughout.
REQ-037 Check: rst pulled low mid-BUSY -> IDLE and stalls=0 asynchronously; divreadyE afterwards has no effect.
REQ-038 Check: lwstall condition together with divE in IDLE -> flushE=0 and stallE=1 (divide priority).
